demux_burst_scheduler: RTL and testbench

//  Sequences the 8-bit 1-to-4 demultiplexer. Accepts a valid/ready byte stream,

---
 rtl/demux_burst_scheduler.sv | 149 ++++++++++++++
 tb/tb_demux_burst_scheduler.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/demux_burst_scheduler.sv
// demux_burst_scheduler
// Feeds the 8-bit 1-to-4 demultiplexer from a valid/ready byte stream.
// A one-entry output register holds the byte and its channel select.
// Bursts of BURST bytes either rotate over channels A..D or stay on cfg_sel.
// A burst is never split across channels.
// A stalled channel stalls the whole stream; no channel is ever skipped.

module demux_burst_scheduler #(
    parameter int BURST = 4,
    parameter int CNT_W = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       mode,
    input  logic [1:0] cfg_sel,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] out_data,
    output logic [1:0] out_sel,
    output logic [3:0] out_valid,
    input  logic [3:0] out_ready,
    output logic       burst_done
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BURST - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state_q;
    state_t           state_d;
    logic [1:0]       ptr_q;
    logic [1:0]       ptr_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             mode_q;
    logic             mode_d;

    logic             vld_p0;
    logic [7:0]       data_p0;
    logic [1:0]       sel_p0;
    logic             done_p0;

    logic             accept;
    logic             drain;
    logic             last_beat;
    logic [1:0]       sel_src;

    // One-hot channel valid for a given select value
    function automatic logic [3:0] sel_onehot(input logic [1:0] s);
        return 4'b0001 << s;
    endfunction

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: a burst is closed only by the accept of its final byte
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept && !last_beat) state_d = ST_BURST;
            ST_BURST: if (accept && last_beat)  state_d = ST_IDLE;
        endcase
    end

    // Handshake, channel source and pointer/counter updates
    always_comb begin
        drain     = vld_p0 && out_ready[sel_p0];
        in_ready  = !vld_p0 || out_ready[sel_p0];
        accept    = in_valid && in_ready;
        last_beat = (cnt_q == LAST_CNT);
        sel_src   = ptr_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        mode_d    = mode_q;
        case (state_q)
            ST_IDLE: begin
                // Only IDLE looks at mode/cfg_sel, so a running burst ignores them
                if (mode) begin
                    sel_src = cfg_sel;
                    ptr_d   = cfg_sel;
                end
                if (accept) begin
                    mode_d = mode;
                    if (last_beat) begin
                        cnt_d = '0;
                        if (!mode) ptr_d = ptr_q + 2'd1;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end
            ST_BURST: begin
                if (accept) begin
                    if (last_beat) begin
                        cnt_d = '0;
                        if (!mode_q) ptr_d = ptr_q + 2'd1;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end
        endcase
    end

    // Control registers: pointer, burst counter, burst mode, full flag, done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q   <= 2'd0;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
            vld_p0  <= 1'b0;
            done_p0 <= 1'b0;
        end else begin
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            vld_p0  <= accept || (vld_p0 && !drain);
            done_p0 <= accept && last_beat;
        end
    end

    // Output data register: reloads on every accept, holds otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_p0 <= 8'd0;
            sel_p0  <= 2'd0;
        end else if (accept) begin
            data_p0 <= in_data;
            sel_p0  <= sel_src;
        end
    end

    assign out_data   = data_p0;
    assign out_sel    = sel_p0;
    assign out_valid  = vld_p0 ? sel_onehot(sel_p0) : 4'b0000;
    assign burst_done = done_p0;

endmodule

// File: tb/tb_demux_burst_scheduler.sv
// Directed bench for demux_burst_scheduler (BURST = 4).
// Inputs change on the falling edge; outputs are sampled on the falling edge.

module tb_demux_burst_scheduler;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       mode;
    logic [1:0] cfg_sel;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic [1:0] out_sel;
    logic [3:0] out_valid;
    logic [3:0] out_ready;
    logic       burst_done;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    demux_burst_scheduler #(.BURST(4), .CNT_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mode       (mode),
        .cfg_sel    (cfg_sel),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_sel    (out_sel),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .burst_done (burst_done)
    );

    task automatic do_reset;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        mode      = 1'b0;
        cfg_sel   = 2'b00;
        out_ready = 4'hF;
        rst_n     = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Power-up reset, then reset in the middle of a B burst
    task automatic test_reset;
        logic [14:0] got;
        logic [14:0] exp;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        mode      = 1'b0;
        cfg_sel   = 2'b00;
        out_ready = 4'hF;
        rst_n     = 1'b1;
        #2 rst_n  = 1'b0;
        @(negedge clk);
        got = {out_valid, out_sel, out_data, burst_done};
        n_cmp++;
        if (got !== 15'd0) begin
            n_err++;
            $display("FAIL reset_outputs got %h want %h", got, 15'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_in_ready got %b want 1", in_ready);
        end
        // Six bytes: four on A, two on B
        in_valid = 1'b1;
        in_data  = 8'h50;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i < 5) in_data = 8'(8'h50 + i + 1);
            else       in_valid = 1'b0;
        end
        n_cmp++;
        if (out_sel !== 2'b01 || out_data !== 8'h55) begin
            n_err++;
            $display("FAIL pre_reset_byte got sel=%b data=%h want sel=01 data=55", out_sel, out_data);
        end
        rst_n = 1'b0;
        #1;
        got = {out_valid, out_sel, out_data, burst_done};
        n_cmp++;
        if (got !== 15'd0) begin
            n_err++;
            $display("FAIL midburst_reset_outputs got %h want %h", got, 15'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 4'b0000) begin
            n_err++;
            $display("FAIL post_reset got in_ready=%b out_valid=%b want 1 0000", in_ready, out_valid);
        end
        in_valid = 1'b1;
        in_data  = 8'hA5;
        @(negedge clk);
        in_valid = 1'b0;
        got = {out_valid, out_sel, out_data, burst_done};
        exp = {4'b0001, 2'b00, 8'hA5, 1'b0};
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL post_reset_ptr_A got %h want %h", got, exp);
        end
        @(negedge clk);
    endtask

    // Round-robin: 16 back-to-back bytes over A, B, C, D
    task automatic test_round_robin;
        logic [14:0] got;
        logic [14:0] exp;
        do_reset();
        in_data  = 8'h00;
        in_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            got = {out_valid, out_sel, out_data, burst_done};
            exp = {4'(1 << (i / 4)), 2'(i / 4), 8'(i), (i % 4 == 3)};
            n_cmp++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL rr_byte%0d got %h want %h", i, got, exp);
            end
            n_cmp++;
            if (in_ready !== 1'b1) begin
                n_err++;
                $display("FAIL rr_in_ready%0d got %b want 1", i, in_ready);
            end
            if (i < 15) in_data = 8'(i + 1);
            else        in_valid = 1'b0;
        end
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 4'b0000 || burst_done !== 1'b0) begin
            n_err++;
            $display("FAIL rr_drain got valid=%b done=%b want 0000 0", out_valid, burst_done);
        end
    endtask

    // After the D burst the pointer wraps back to A (relies on test_round_robin state)
    task automatic test_wrap;
        logic [14:0] got;
        logic [14:0] exp;
        in_valid = 1'b1;
        in_data  = 8'h10;
        @(negedge clk);
        in_valid = 1'b0;
        got = {out_valid, out_sel, out_data, burst_done};
        exp = {4'b0001, 2'b00, 8'h10, 1'b0};
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL wrap_to_A got %h want %h", got, exp);
        end
        @(negedge clk);
    endtask

    // Fixed channel C, cfg_sel flipped to B mid-burst takes effect at the next burst
    task automatic test_fixed;
        logic [14:0] got;
        logic [14:0] exp;
        logic [1:0]  esel;
        do_reset();
        mode     = 1'b1;
        cfg_sel  = 2'b10;
        in_data  = 8'h20;
        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            esel = (i < 4) ? 2'b10 : 2'b01;
            got  = {out_valid, out_sel, out_data, burst_done};
            exp  = {4'(1 << esel), esel, 8'(8'h20 + i), (i % 4 == 3)};
            n_cmp++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL fixed_byte%0d got %h want %h", i, got, exp);
            end
            if (i == 2) cfg_sel = 2'b01;
            if (i < 7) in_data = 8'(8'h20 + i + 1);
            else       in_valid = 1'b0;
        end
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 4'b0000) begin
            n_err++;
            $display("FAIL fixed_drain got %b want 0000", out_valid);
        end
        // Pointer now rests on the last fixed channel (B); RR resumes from there
        mode     = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'h28;
        @(negedge clk);
        in_valid = 1'b0;
        n_cmp++;
        if (out_sel !== 2'b01 || out_valid !== 4'b0010) begin
            n_err++;
            $display("FAIL fixed_ptr got sel=%b valid=%b want 01 0010", out_sel, out_valid);
        end
        @(negedge clk);
    endtask

    // Channel B stalls for three cycles while it holds byte 0x34
    task automatic test_backpressure;
        logic [14:0] got;
        logic [14:0] exp;
        do_reset();
        in_data  = 8'h30;
        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            got = {out_valid, out_sel, out_data, burst_done};
            exp = {4'(1 << (i / 4)), 2'(i / 4), 8'(8'h30 + i), (i % 4 == 3)};
            n_cmp++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL bp_byte%0d got %h want %h", i, got, exp);
            end
            if (i == 4) begin
                out_ready = 4'b1101;
                in_data   = 8'h35;
                #1;
                n_cmp++;
                if (in_ready !== 1'b0) begin
                    n_err++;
                    $display("FAIL bp_stall_ready got %b want 0", in_ready);
                end
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    got = {out_valid, out_sel, out_data, burst_done};
                    exp = {4'b0010, 2'b01, 8'h34, 1'b0};
                    n_cmp++;
                    if (got !== exp || in_ready !== 1'b0) begin
                        n_err++;
                        $display("FAIL bp_hold%0d got %h rdy=%b want %h rdy=0", k, got, in_ready, exp);
                    end
                end
                out_ready = 4'hF;
                #1;
                n_cmp++;
                if (in_ready !== 1'b1) begin
                    n_err++;
                    $display("FAIL bp_release_ready got %b want 1", in_ready);
                end
            end else if (i < 7) begin
                in_data = 8'(8'h30 + i + 1);
            end else begin
                in_valid = 1'b0;
            end
        end
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 4'b0000) begin
            n_err++;
            $display("FAIL bp_drain got %b want 0000", out_valid);
        end
    endtask

    // Drain and accept in the same cycle: no bubble between 0x40..0x47
    task automatic test_back_to_back;
        do_reset();
        in_data  = 8'h40;
        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            n_cmp++;
            if (out_valid === 4'b0000 || out_data !== 8'(8'h40 + i)) begin
                n_err++;
                $display("FAIL b2b_byte%0d got valid=%b data=%h want nonzero %h",
                         i, out_valid, out_data, 8'(8'h40 + i));
            end
            if (i < 7) in_data = 8'(8'h40 + i + 1);
            else       in_valid = 1'b0;
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_wrap();
        test_fixed();
        test_backpressure();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
